reg_bank_cols: RTL
==================

Name: reg_bank_cols

Overview:
Register storage array that sits directly upstream of the per-bit 8:1 read-select muxes in the register file. Holds NUM_REGS words of WIDTH bits, with one synchronous write port and a per-register busy scoreboard. Presents its contents bit-column-major, so each WIDTH bit position forms one contiguous NUM_REGS-bit group that drives one read mux. The top register index is a hardwired zero register.

Parameters:
NUM_REGS  8  number of registers; must be a power of 2; equals read-mux fan-in
WIDTH  8  bits per register
ADDR_W  3  register address width; must equal log2(NUM_REGS)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
wr_en  input  1  write request this cycle
wr_addr  input  ADDR_W  write target register
wr_data  input  WIDTH  write data
rsv_en  input  1  reserve request: mark a register busy (pending result)
rsv_addr  input  ADDR_W  register to reserve
col_q  output  WIDTH*NUM_REGS  bit-column-major contents: col_q[b*NUM_REGS + r] = bit b of register r
busy  output  NUM_REGS  busy[r]=1 while register r has a pending write
wr_ack  output  1  registered pulse: previous cycle's write was accepted
wr_nop  output  1  registered pulse: previous cycle's write targeted the zero register and was discarded

Behaviour:
- Reset: asynchronous on reset_n low. All registers = 0, busy = 0, wr_ack = 0, wr_nop = 0. State holds while reset_n is low. Outputs are valid from the first rising edge after reset_n is released. A reset mid-operation discards any in-flight write or reserve.
- Zero register: index ZR = NUM_REGS-1. It always reads 0, and busy[ZR] is always 0.
- Write: on a rising edge with wr_en=1 and wr_addr != ZR, reg[wr_addr] <= wr_data and busy[wr_addr] <= 0. The next cycle, wr_ack=1 and wr_nop=0.
- Write to ZR: data is discarded. The next cycle, wr_nop=1 and wr_ack=0.
- Without wr_en: wr_ack=0 and wr_nop=0 on the following cycle.
- Write latency: new data appears on col_q one cycle after the write edge. There is no write-to-read bypass; same-cycle readers see the old value.
- Write address decode: one-hot enables from a ADDR_W-to-NUM_REGS decoder gated by wr_en. At most one register updates per edge.
- Reserve: on a rising edge with rsv_en=1 and rsv_addr != ZR, busy[rsv_addr] <= 1. A reserve to ZR is ignored.
- Simultaneous write and reserve, different addresses: both take effect.
- Simultaneous write and reserve, same address: data is written, and busy ends at 1 (reserve wins, representing a newer pending producer).
- Write to a non-busy register: legal. Data is written and busy stays 0.
- Reserve of an already-busy register: busy stays 1. There is no counting.
- col_q and busy are purely registered state with no combinational path from inputs.
- Unused/illegal: none. All ADDR_W codes are valid indices.

Test Plan:
1. Assert reset_n=0 mid-run after several writes, then release -> col_q=0 and busy=0 immediately on assertion; wr_ack=0; first write after release behaves normally.
2. Write wr_addr=3, wr_data=8'hA5 -> next cycle col_q bits {b*8+3} = A5 (bits 0,2,5,7 set in register 3's column slot); wr_ack=1; all other registers unchanged.
3. Write wr_addr=7 (ZR), wr_data=8'hFF -> register 7 column bits stay 0; wr_nop=1 and wr_ack=0 next cycle.
4. Reserve rsv_addr=2, then write wr_addr=2 with 8'h3C two cycles later -> busy=8'b0000_0100 after the reserve; busy=0 and register 2=3C one cycle after the write.
5. Same edge: rsv_addr=5 and wr_addr=5 with wr_data=8'h11 -> register 5=11 and busy[5]=1. Same edge with rsv_addr=1 and wr_addr=4 -> both apply.
6. Write all registers 0..6 with value r*8'h11, then sweep a downstream 8:1 mux selector 0..7 on bit column b -> selected bit equals bit b of r*8'h11, and 0 for r=7.

Source files
------------

// File: rtl/reg_bank_cols.sv
// Register storage with a per-register busy scoreboard, exposed bit-column-major so each bit
// position forms one NUM_REGS-wide group feeding a downstream read-select mux.
module reg_bank_cols #(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned ADDR_W   = 3
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      wr_en,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      rsv_en,
  input  logic [ADDR_W-1:0]         rsv_addr,
  output logic [WIDTH*NUM_REGS-1:0] col_q,
  output logic [NUM_REGS-1:0]       busy,
  output logic                      wr_ack,
  output logic                      wr_nop
);

  localparam logic [ADDR_W-1:0] ZR = ADDR_W'(NUM_REGS - 1);

  logic [NUM_REGS-1:0][WIDTH-1:0] regs_d, regs_q;
  logic [NUM_REGS-1:0]            busy_d, busy_q;
  logic [NUM_REGS-1:0]            wr_sel, rsv_sel;
  logic                           wr_ack_d, wr_ack_q;
  logic                           wr_nop_d, wr_nop_q;

  // One-hot decoders; the zero register never gets a select.
  always_comb begin
    wr_sel  = '0;
    rsv_sel = '0;
    for (int r = 0; r < NUM_REGS - 1; r++) begin
      wr_sel[r]  = wr_en  && (wr_addr  == ADDR_W'(r));
      rsv_sel[r] = rsv_en && (rsv_addr == ADDR_W'(r));
    end
  end

  always_comb begin
    regs_d = regs_q;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (wr_sel[r]) begin
        regs_d[r] = wr_data;
      end
    end
    regs_d[NUM_REGS-1] = '0;
    // Reserve is applied after the write clear so a same-address reserve wins.
    busy_d   = (busy_q & ~wr_sel) | rsv_sel;
    wr_ack_d = wr_en && (wr_addr != ZR);
    wr_nop_d = wr_en && (wr_addr == ZR);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regs_q   <= '0;
      busy_q   <= '0;
      wr_ack_q <= 1'b0;
      wr_nop_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      busy_q   <= busy_d;
      wr_ack_q <= wr_ack_d;
      wr_nop_q <= wr_nop_d;
    end
  end

  for (genvar b = 0; b < WIDTH; b++) begin : g_col
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_row
      assign col_q[b*NUM_REGS + r] = regs_q[r][b];
    end
  end

  assign busy   = busy_q;
  assign wr_ack = wr_ack_q;
  assign wr_nop = wr_nop_q;

endmodule
